// File: rtl/decomp_pkg.sv
// Shared constants and types for the decompressor output path.
package decomp_pkg;

    // Bytes per AXIS beat on both sides of the packer.
    localparam int DATA_BYTES = 32;

    // Staging buffer holds two beats so a full beat can leave while the next one fills.
    localparam int BUF_BYTES = 2 * DATA_BYTES;

    // Packer control: FILL accepts input, FLUSH drains the tail of a packet.
    typedef enum logic {
        FILL  = 1'b0,
        FLUSH = 1'b1
    } state_t;

endpackage

// File: rtl/keep_popcount.sv
// Counts the enabled bytes of a tkeep word and reports whether they are
// packed from bit 0 upwards with no holes.
module keep_popcount #(
    parameter int W = 32
) (
    input  logic [W-1:0]           keep,
    output logic [$clog2(W+1)-1:0] count,
    output logic                   contiguous
);

    localparam int CW = $clog2(W + 1);

    // Population count of the byte enables.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can leave it unassigned and infer a latch.
        count = '0;
        for (int i = 0; i < W; i++) begin
            count = count + CW'(keep[i]);
        end
    end

    // A run of ones starting at bit 0 has no bit in common with itself plus one.
    assign contiguous = ((keep & (keep + W'(1))) == '0);

endmodule

// File: rtl/axis_byte_packer.sv
// Packs variable-length AXIS beats from the byte decompressor into full
// DATA_BYTES-wide beats, keeping byte order and closing each packet with a
// tlast beat (full, partial, or empty for a zero-byte tail).
module axis_byte_packer #(
    parameter int DATA_BYTES = decomp_pkg::DATA_BYTES
) (
    input  logic                      axis_aclk,
    input  logic                      axis_aresetn,
    input  logic [DATA_BYTES*8-1:0]   axis_tdata,
    input  logic [DATA_BYTES-1:0]     axis_tkeep,
    input  logic                      axis_tvalid,
    input  logic                      axis_tlast,
    output logic                      axis_tready,
    output logic [DATA_BYTES*8-1:0]   axis_tdata_c2s,
    output logic [DATA_BYTES-1:0]     axis_tkeep_c2s,
    output logic                      axis_tvalid_c2s,
    output logic                      axis_tlast_c2s,
    input  logic                      axis_tready_c2s,
    output logic                      err_keep
);

    import decomp_pkg::*;

    localparam int DW    = DATA_BYTES * 8;
    localparam int BW    = BUF_BYTES * 8;
    localparam int CW    = $clog2(DATA_BYTES + 1);
    localparam int FW    = $clog2(BUF_BYTES + 1);
    localparam logic [FW-1:0] BEAT = FW'(DATA_BYTES);

    state_t              state_q, state_d;
    logic [FW-1:0]       fill_q, fill_d, fill_base;
    logic [BW-1:0]       buf_q, buf_d;
    logic [DW-1:0]       out_data_q, out_data_d;
    logic [DATA_BYTES-1:0] out_keep_q, out_keep_d;
    logic                out_valid_q, out_valid_d;
    logic                out_last_q, out_last_d;
    logic                err_q, err_d;

    logic [DW-1:0]       compact;
    int                  pos;
    logic [CW-1:0]       n_bytes;
    logic                keep_ok;
    logic                out_free, pop_full, pop_tail, accept;

    keep_popcount #(.W(DATA_BYTES)) u_keep_popcount (
        .keep       (axis_tkeep),
        .count      (n_bytes),
        .contiguous (keep_ok)
    );

    // Gather enabled input bytes to the bottom of the word in index order;
    // bytes above the count come out zero.
    always_comb begin
        compact = '0;
        pos     = 0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            if (axis_tkeep[i]) begin
                compact[pos*8 +: 8] = axis_tdata[i*8 +: 8];
                pos = pos + 1;
            end
        end
    end

    // Pop/append decision, next buffer contents, output register and state.
    always_comb begin
        out_free  = !out_valid_q || axis_tready_c2s;
        pop_full  = out_free && (fill_q >= BEAT);
        pop_tail  = out_free && (state_q == FLUSH) && (fill_q < BEAT);
        fill_base = pop_full ? (fill_q - BEAT) : (pop_tail ? '0 : fill_q);

        axis_tready = axis_aresetn && (state_q == FILL) && (fill_base <= BEAT);
        accept      = axis_tvalid && axis_tready;

        state_d     = state_q;
        fill_d      = fill_base;
        buf_d       = buf_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_valid_d = out_valid_q && !axis_tready_c2s;
        out_last_d  = out_last_q;
        err_d       = err_q || (accept && !keep_ok);

        if (pop_full) begin
            out_data_d  = buf_q[DW-1:0];
            out_keep_d  = '1;
            out_valid_d = 1'b1;
            out_last_d  = (state_q == FLUSH) && (fill_q == BEAT);
            buf_d       = buf_q >> DW;
            if ((state_q == FLUSH) && (fill_q == BEAT)) begin
                state_d = FILL;
            end
        end else if (pop_tail) begin
            // Bytes above fill are always zero, so the low half is already a clean tail.
            out_data_d  = buf_q[DW-1:0];
            out_keep_d  = ~({DATA_BYTES{1'b1}} << fill_q);
            out_valid_d = 1'b1;
            out_last_d  = 1'b1;
            buf_d       = '0;
            state_d     = FILL;
        end

        // Append after the pop so a simultaneous pop and accept behaves as pop-then-append.
        if (accept) begin
            buf_d  = buf_d | ({{DW{1'b0}}, compact} << {fill_base, 3'b000});
            fill_d = fill_base + FW'(n_bytes);
            if (axis_tlast) begin
                state_d = FLUSH;
            end
        end
    end

    // Register stage with synchronous active-low reset.
    always_ff @(posedge axis_aclk) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
        if (!axis_aresetn) begin
            state_q     <= FILL;
            fill_q      <= '0;
            // NOTE: the staging buffer is reset too, because the OR-append relies on bytes above fill being zero.
            buf_q       <= '0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            fill_q      <= fill_d;
            buf_q       <= buf_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            err_q       <= err_d;
        end
    end

    assign axis_tdata_c2s  = out_data_q;
    assign axis_tkeep_c2s  = out_keep_q;
    assign axis_tvalid_c2s = out_valid_q;
    assign axis_tlast_c2s  = out_last_q;
    assign err_keep        = err_q;

endmodule

// File: tb/tb_axis_byte_packer.sv
// Directed bench for axis_byte_packer: full-beat packing, partial and empty
// tails, backpressure, non-contiguous keep and mid-packet reset.
module tb_axis_byte_packer;

    logic         axis_aclk = 1'b0;
    logic         axis_aresetn;
    logic [255:0] axis_tdata;
    logic [31:0]  axis_tkeep;
    logic         axis_tvalid;
    logic         axis_tlast;
    logic         axis_tready;
    logic [255:0] axis_tdata_c2s;
    logic [31:0]  axis_tkeep_c2s;
    logic         axis_tvalid_c2s;
    logic         axis_tlast_c2s;
    logic         axis_tready_c2s;
    logic         err_keep;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [255:0] d;
        logic [31:0]  k;
        logic         l;
    } beat_t;

    beat_t cap_q[$];

    axis_byte_packer dut (
        .axis_aclk       (axis_aclk),
        .axis_aresetn    (axis_aresetn),
        .axis_tdata      (axis_tdata),
        .axis_tkeep      (axis_tkeep),
        .axis_tvalid     (axis_tvalid),
        .axis_tlast      (axis_tlast),
        .axis_tready     (axis_tready),
        .axis_tdata_c2s  (axis_tdata_c2s),
        .axis_tkeep_c2s  (axis_tkeep_c2s),
        .axis_tvalid_c2s (axis_tvalid_c2s),
        .axis_tlast_c2s  (axis_tlast_c2s),
        .axis_tready_c2s (axis_tready_c2s),
        .err_keep        (err_keep)
    );

    always #5 axis_aclk = ~axis_aclk;

    // Inputs change 1 ns after a rising edge, so at the falling edge a visible
    // valid/ready pair is exactly the handshake the next rising edge completes.
    always @(negedge axis_aclk) begin
        if (axis_aresetn && axis_tvalid_c2s && axis_tready_c2s) begin
            cap_q.push_back('{d: axis_tdata_c2s, k: axis_tkeep_c2s, l: axis_tlast_c2s});
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Beat whose first n bytes count up from s; remaining bytes are filled with f.
    function automatic logic [255:0] mk(input logic [7:0] s, input int n, input logic [7:0] f);
        logic [255:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i*8 +: 8] = (i < n) ? (s + 8'(i)) : f;
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge axis_aclk);
        #1;
    endtask

    task automatic send(input logic [255:0] d, input logic [31:0] k, input logic l);
        int t;
        t = 0;
        axis_tdata  = d;
        axis_tkeep  = k;
        axis_tlast  = l;
        axis_tvalid = 1'b1;
        @(negedge axis_aclk);
        while (!axis_tready && t < 50) begin
            @(negedge axis_aclk);
            t++;
        end
        checks++;
        assert (axis_tready === 1'b1) else begin
            errors++;
            $error("FAIL send_timeout: tready=%b required 1", axis_tready);
        end
        tick();
        axis_tvalid = 1'b0;
        axis_tlast  = 1'b0;
        axis_tkeep  = '0;
        axis_tdata  = '0;
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %b required %b", tag, got, exp);
        end
    endtask

    task automatic check_count(input string tag, input int exp);
        checks++;
        assert (cap_q.size() === exp) else begin
            errors++;
            $error("FAIL %s: got %0d beats required %0d", tag, cap_q.size(), exp);
        end
    endtask

    task automatic check_beat(input string tag, input logic [255:0] d, input logic [31:0] k, input logic l);
        beat_t b;
        checks++;
        if (cap_q.size() == 0) begin
            errors++;
            $error("FAIL %s: no output beat captured, required keep=%h last=%b", tag, k, l);
        end else begin
            b = cap_q.pop_front();
            assert (b.d === d && b.k === k && b.l === l) else begin
                errors++;
                $error("FAIL %s: got data=%h keep=%h last=%b required data=%h keep=%h last=%b",
                       tag, b.d, b.k, b.l, d, k, l);
            end
        end
    endtask

    initial begin
        axis_aresetn    = 1'b0;
        axis_tdata      = '0;
        axis_tkeep      = '0;
        axis_tvalid     = 1'b0;
        axis_tlast      = 1'b0;
        axis_tready_c2s = 1'b1;

        // Reset values, observed while reset is still held.
        tick();
        tick();
        @(negedge axis_aclk);
        chk1("rst_tready", axis_tready, 1'b0);
        chk1("rst_tvalid_c2s", axis_tvalid_c2s, 1'b0);
        chk1("rst_tlast_c2s", axis_tlast_c2s, 1'b0);
        chk1("rst_err_keep", err_keep, 1'b0);
        checks++;
        assert (axis_tkeep_c2s === 32'h0 && axis_tdata_c2s === 256'h0) else begin
            errors++;
            $error("FAIL rst_data_keep: got keep=%h data=%h required 0", axis_tkeep_c2s, axis_tdata_c2s);
        end
        tick();
        axis_aresetn = 1'b1;
        tick();

        // Four 16-byte beats pack into two full beats in byte order.
        cap_q.delete();
        send(mk(8'h00, 16, 8'hAA), 32'h0000_FFFF, 1'b0);
        send(mk(8'h10, 16, 8'hAA), 32'h0000_FFFF, 1'b0);
        send(mk(8'h20, 16, 8'hAA), 32'h0000_FFFF, 1'b0);
        send(mk(8'h30, 16, 8'hAA), 32'h0000_FFFF, 1'b0);
        repeat (6) tick();
        check_count("pack16_count", 2);
        check_beat("pack16_beat0", mk(8'h00, 32, 8'h00), 32'hFFFF_FFFF, 1'b0);
        check_beat("pack16_beat1", mk(8'h20, 32, 8'h00), 32'hFFFF_FFFF, 1'b0);

        // 40-byte packet: a full beat followed by an 8-byte tlast tail.
        cap_q.delete();
        send(mk(8'h40, 32, 8'hAA), 32'hFFFF_FFFF, 1'b0);
        send(mk(8'h60, 8, 8'hAA), 32'h0000_00FF, 1'b1);
        repeat (6) tick();
        check_count("p40_count", 2);
        check_beat("p40_full", mk(8'h40, 32, 8'h00), 32'hFFFF_FFFF, 1'b0);
        check_beat("p40_tail", mk(8'h60, 8, 8'h00), 32'h0000_00FF, 1'b1);

        // 64-byte packet ending on a beat boundary: no trailing empty beat.
        cap_q.delete();
        send(mk(8'h70, 32, 8'hAA), 32'hFFFF_FFFF, 1'b0);
        send(mk(8'h90, 32, 8'hAA), 32'hFFFF_FFFF, 1'b1);
        repeat (6) tick();
        check_count("p64_count", 2);
        check_beat("p64_beat0", mk(8'h70, 32, 8'h00), 32'hFFFF_FFFF, 1'b0);
        check_beat("p64_beat1", mk(8'h90, 32, 8'h00), 32'hFFFF_FFFF, 1'b1);

        // Backpressure: buffer fills to 64 bytes, input stalls, output beat holds.
        cap_q.delete();
        axis_tready_c2s = 1'b0;
        send(mk(8'h80, 32, 8'hAA), 32'hFFFF_FFFF, 1'b0);
        send(mk(8'hA0, 32, 8'hAA), 32'hFFFF_FFFF, 1'b0);
        send(mk(8'hC0, 32, 8'hAA), 32'hFFFF_FFFF, 1'b0);
        axis_tdata  = mk(8'hE0, 32, 8'hAA);
        axis_tkeep  = 32'hFFFF_FFFF;
        axis_tvalid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge axis_aclk);
            chk1("bp_tready_low", axis_tready, 1'b0);
            checks++;
            assert (axis_tvalid_c2s === 1'b1 && axis_tdata_c2s === mk(8'h80, 32, 8'h00)
                    && axis_tkeep_c2s === 32'hFFFF_FFFF && axis_tlast_c2s === 1'b0) else begin
                errors++;
                $error("FAIL bp_hold: got valid=%b keep=%h data=%h required valid=1 keep=ffffffff data=%h",
                       axis_tvalid_c2s, axis_tkeep_c2s, axis_tdata_c2s, mk(8'h80, 32, 8'h00));
            end
        end
        tick();
        axis_tready_c2s = 1'b1;
        send(mk(8'hE0, 32, 8'hAA), 32'hFFFF_FFFF, 1'b0);
        repeat (8) tick();
        check_count("bp_count", 4);
        check_beat("bp_beat0", mk(8'h80, 32, 8'h00), 32'hFFFF_FFFF, 1'b0);
        check_beat("bp_beat1", mk(8'hA0, 32, 8'h00), 32'hFFFF_FFFF, 1'b0);
        check_beat("bp_beat2", mk(8'hC0, 32, 8'h00), 32'hFFFF_FFFF, 1'b0);
        check_beat("bp_beat3", mk(8'hE0, 32, 8'h00), 32'hFFFF_FFFF, 1'b0);

        // Non-contiguous keep: bytes 0 and 2 are packed, error flag sticks.
        cap_q.delete();
        chk1("err_before", err_keep, 1'b0);
        send({{29{8'hAA}}, 8'h22, 8'h99, 8'h11}, 32'h0000_0005, 1'b0);
        @(negedge axis_aclk);
        chk1("err_set", err_keep, 1'b1);
        tick();
        send(mk(8'h23, 30, 8'hAA), 32'h3FFF_FFFF, 1'b1);
        repeat (6) tick();
        check_count("nc_count", 1);
        check_beat("nc_beat", {mk(8'h23, 30, 8'h00), 8'h22, 8'h11} , 32'hFFFF_FFFF, 1'b1);

        // Zero-byte tail at fill 0 produces one empty tlast beat.
        send({32{8'h5A}}, 32'h0000_0000, 1'b1);
        repeat (6) tick();
        check_count("empty_count", 1);
        check_beat("empty_beat", 256'h0, 32'h0000_0000, 1'b1);
        @(negedge axis_aclk);
        chk1("err_sticky", err_keep, 1'b1);
        tick();

        // Reset mid-packet with 20 bytes staged; the next packet is clean.
        cap_q.delete();
        send(mk(8'hF0, 20, 8'hAA), 32'h000F_FFFF, 1'b0);
        axis_aresetn = 1'b0;
        @(negedge axis_aclk);
        chk1("mid_rst_tready", axis_tready, 1'b0);
        tick();
        axis_aresetn = 1'b1;
        @(negedge axis_aclk);
        chk1("mid_rst_tvalid_c2s", axis_tvalid_c2s, 1'b0);
        chk1("mid_rst_err_clear", err_keep, 1'b0);
        tick();
        send(mk(8'h30, 32, 8'hAA), 32'hFFFF_FFFF, 1'b1);
        @(negedge axis_aclk);
        chk1("lat_before", axis_tvalid_c2s, 1'b0);
        @(negedge axis_aclk);
        chk1("lat_after", axis_tvalid_c2s, 1'b1);
        repeat (6) tick();
        check_count("after_rst_count", 1);
        check_beat("after_rst_beat", mk(8'h30, 32, 8'h00), 32'hFFFF_FFFF, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axis_byte_packer.md
AXIS_BYTE_PACKER -- requirements
Module: axis_byte_packer

Interface
REQ-001 SHALL have parameter DATA_BYTES, default 32, the number of bytes per AXIS beat.
REQ-002 SHALL have port axis_aclk, input, 1, the single clock; all logic is on the rising edge.
REQ-003 SHALL have port axis_aresetn, input, 1, reset; it is synchronous and active-low.
REQ-004 SHALL have port axis_tdata, input, 256, upstream decompressed bytes; byte i is [8i+7:8i].
REQ-005 SHALL have port axis_tkeep, input, 32, upstream byte enables; they are contiguous from bit 0.
REQ-006 SHALL have ports axis_tvalid and axis_tlast, input, 1 each, the upstream handshake and end of packet.
REQ-007 SHALL have port axis_tready, output, 1, the upstream accept.
REQ-008 SHALL have ports axis_tdata_c2s (output, 256), axis_tkeep_c2s (output, 32), axis_tvalid_c2s (output, 1) and axis_tlast_c2s (output, 1), carrying the packed stream.
REQ-009 SHALL have port axis_tready_c2s, input, 1, the downstream accept.
REQ-010 SHALL have port err_keep, output, 1, a sticky flag for non-contiguous tkeep.

Function
REQ-011 SHALL pack the variable-length beats produced by the 8-bit decompressor into full 32-byte beats, preserving byte order.
REQ-012 SHALL count as accepted a beat with axis_tvalid && axis_tready, carrying n = popcount(axis_tkeep) bytes, where 0 <= n <= 32.
REQ-013 SHALL hold a 64-byte staging buffer and a 7-bit fill count (0..64).
REQ-014 SHALL write accepted bytes at buffer offset fill', where fill' = fill - 32 if a beat is popped in the same cycle, else fill.
REQ-015 SHALL drive axis_tready = (state == FILL) && (fill' <= 32).
REQ-016 SHALL pop a full beat into the output register when fill >= 32 and the output register is empty or its beat is accepted this cycle; the beat is the low 32 bytes with tkeep_c2s = 32'hFFFF_FFFF, and the buffer shifts down 32 bytes.
REQ-017 SHALL update fill as fill + n - 32*pop every cycle.
REQ-018 SHALL hold tdata, tkeep and tlast of the output register stable while axis_tvalid_c2s && !axis_tready_c2s.
REQ-019 SHALL implement a state machine with states FILL and FLUSH.
REQ-020 SHALL move FILL -> FLUSH when a beat is accepted with axis_tlast = 1.
REQ-021 SHALL move FLUSH -> FILL in the cycle the beat carrying tlast_c2s = 1 is loaded into the output register.
REQ-022 SHALL, in FLUSH, set tlast_c2s = 1 on a popped full beat when it empties the buffer (fill == 32).
REQ-023 SHALL, in FLUSH with 0 < fill < 32, emit a partial beat with tkeep_c2s = (1 << fill) - 1, tlast_c2s = 1 and upper bytes zero.
REQ-024 SHALL, in FLUSH with fill == 0 and no tlast beat yet issued (zero-byte tail), emit a beat with tkeep_c2s = 0 and tlast_c2s = 1.
REQ-025 SHALL give 1-cycle latency: a beat accepted at edge k that makes fill >= 32 (or a tlast beat) produces axis_tvalid_c2s high after edge k+1.
REQ-026 SHALL, when tkeep is non-contiguous, set err_keep to 1 until reset and still count n by popcount, packing bytes in index order.
REQ-027 SHALL give simultaneous output pop and input accept a combined result equal to pop-then-append.

Reset
REQ-028 SHALL, while axis_aresetn == 0 at a clock edge, clear fill to 0, state to FILL, axis_tvalid_c2s, axis_tlast_c2s and err_keep to 0, axis_tkeep_c2s to 0, axis_tdata_c2s to 0, and drive axis_tready low.
REQ-029 SHALL discard any in-flight partial packet on reset mid-packet; the first beat after reset starts a new packet.

Structure
REQ-030 SHALL place DATA_BYTES, BUF_BYTES = 64 and the state enum FILL/FLUSH in the shared package decomp_pkg.
REQ-031 SHALL use one sub-module, keep_popcount: a 32-bit popcount plus contiguity check, combinational.

Verification
REQ-032 SHALL cover: four input beats of tkeep 0x0000FFFF (16 B each), no backpressure -> two output beats with tkeep 0xFFFFFFFF, bytes in order.
REQ-033 SHALL cover: 40 B packet (beats of 32 B then 8 B, tlast on the second) -> output of a full beat, then a beat with tkeep 0x000000FF and tlast = 1.
REQ-034 SHALL cover: 64 B packet ending exactly on a boundary -> two full beats, tlast on the second, and no empty beat.
REQ-035 SHALL cover: axis_tready_c2s held low for 10 cycles with fill reaching 64 -> axis_tready = 0 and output beat stable, with no data loss after release.
REQ-036 SHALL cover: tkeep 0x00000005 -> err_keep = 1 that stays 1 until reset; tlast beat with tkeep = 0 at fill == 0 -> one beat with tkeep 0 and tlast 1.
REQ-037 SHALL cover: axis_aresetn low for 1 cycle mid-packet with fill = 20 -> fill = 0 and axis_tvalid_c2s = 0, and the next packet is output uncorrupted.
